// File: rtl/pg_operand_stage.sv
// Operand-intake stage in front of the 5-bit prefix carry network.
//
// Accepts operand pairs over valid/ready and turns subtract into add
// (B inverted, carry-in forced to 1). It computes bitwise generate and
// propagate, then folds the effective carry-in into G[0]. As a result,
// the network's C[0] = G[0] is the true carry out of bit 0.
//
// Results are held in an output register (OR) plus one skid entry (SK).
// in_ready comes straight from state, so it never depends on out_ready.
//
// Ports
//   clk, rst        rising-edge clock, synchronous active-high reset
//   in_valid/ready  input handshake; in_a, in_b, in_cin, in_sub carry the beat
//   out_valid/ready output handshake; g_out (carry-folded), p_out, cin_out
//   txn_count       accepted input beats, modulo 2^CNT_W
module pg_operand_stage #(
  parameter int unsigned WIDTH = 5,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  input  logic             in_sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] g_out,
  output logic [WIDTH-1:0] p_out,
  output logic             cin_out,
  output logic [CNT_W-1:0] txn_count
);

  localparam int unsigned EntW = 2 * WIDTH + 1;

  // Encoding is {OR_valid, SK_valid}.
  typedef enum logic [1:0] {
    StEmpty = 2'b00,
    StOne   = 2'b10,
    StFull  = 2'b11
  } state_e;

  state_e            state_q, state_d;
  logic [EntW-1:0]   or_q, or_d;   // {cin, p, g}
  logic [EntW-1:0]   sk_q, sk_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic [WIDTH-1:0]  b_eff, g_new, p_new;
  logic              c_eff;
  logic [EntW-1:0]   new_ent;
  logic              accept, fire;

  always_comb begin
    b_eff    = in_sub ? ~in_b : in_b;
    c_eff    = in_sub | in_cin;
    g_new    = in_a & b_eff;
    p_new    = in_a ^ b_eff;
    g_new[0] = g_new[0] | (p_new[0] & c_eff);
    new_ent  = {c_eff, p_new, g_new};
  end

  assign in_ready  = (state_q != StFull);
  // Masked during reset so nothing is handed downstream in the reset cycle.
  assign out_valid = (state_q != StEmpty) && !rst;
  assign accept    = in_valid && in_ready;
  assign fire      = out_valid && out_ready;

  assign g_out     = or_q[WIDTH-1:0];
  assign p_out     = or_q[2*WIDTH-1:WIDTH];
  assign cin_out   = or_q[EntW-1];
  assign txn_count = cnt_q;

  always_comb begin
    state_d = state_q;
    or_d    = or_q;
    sk_d    = sk_q;
    cnt_d   = accept ? cnt_q + CNT_W'(1) : cnt_q;
    case (state_q)
      StEmpty: begin
        if (accept) begin
          state_d = StOne;
          or_d    = new_ent;
        end
      end
      StOne: begin
        if (accept && fire) begin
          or_d = new_ent;
        end else if (accept) begin
          state_d = StFull;
          sk_d    = new_ent;
        end else if (fire) begin
          state_d = StEmpty;
        end
      end
      StFull: begin
        if (fire) begin
          state_d = StOne;
          or_d    = sk_q;
        end
      end
      default: state_d = StEmpty;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StEmpty;
      or_q    <= '0;
      sk_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      or_q    <= or_d;
      sk_q    <= sk_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule
